// File: rtl/axi_lite_bram_slave.sv
// AXI4-Lite slave on a single-port word-organised block RAM: one transaction at a time,
// byte-strobe writes, DECERR for addresses outside the RAM.
module axi_lite_bram_slave #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] axi_araddr,
    input  logic        axi_arvalid,
    output logic        axi_arready,
    input  logic [2:0]  axi_arprot,
    output logic [31:0] axi_rdata,
    output logic [1:0]  axi_rresp,
    output logic        axi_rvalid,
    input  logic        axi_rready,
    input  logic [31:0] axi_awaddr,
    input  logic        axi_awvalid,
    output logic        axi_awready,
    input  logic [2:0]  axi_awprot,
    input  logic [31:0] axi_wdata,
    input  logic [3:0]  axi_wstrb,
    input  logic        axi_wvalid,
    output logic        axi_wready,
    output logic [1:0]  axi_bresp,
    output logic        axi_bvalid,
    input  logic        axi_bready
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {IDLE, W_WAIT, WRITE, B_RESP, READ, R_RESP} state_e;

    state_e                  state_q, state_d;
    logic [31:0]             mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0]   aw_idx_q, ar_idx_q;
    logic                    aw_oor_q, ar_oor_q;
    logic                    aw_got_q, w_got_q;
    logic [31:0]             wdata_q;
    logic [3:0]              wstrb_q;
    logic [31:0]             ram_rd_q, rdata_q;
    logic [1:0]              rresp_q, bresp_q;
    logic                    rvalid_q, bvalid_q;
    logic                    aw_hs, w_hs, ar_hs;
    logic                    unused_bits;

    function automatic logic addr_oor(input logic [31:0] a);
        return |a[31:ADDR_WIDTH+2];
    endfunction

    assign unused_bits = ^{axi_arprot, axi_awprot, axi_awaddr[1:0], axi_araddr[1:0]};

    assign aw_hs = axi_awvalid && axi_awready;
    assign w_hs  = axi_wvalid  && axi_wready;
    assign ar_hs = axi_arvalid && axi_arready;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (aw_hs || w_hs) state_d = (aw_hs && w_hs) ? WRITE : W_WAIT;
                else if (ar_hs)    state_d = READ;
            end
            W_WAIT: if ((aw_got_q || aw_hs) && (w_got_q || w_hs)) state_d = WRITE;
            WRITE:  state_d = B_RESP;
            B_RESP: if (bvalid_q && axi_bready) state_d = IDLE;
            READ:   state_d = R_RESP;
            R_RESP: if (rvalid_q && axi_rready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Readies are a function of state and the write valids only; all forced low in reset.
    always_comb begin
        axi_awready = 1'b0;
        axi_wready  = 1'b0;
        axi_arready = 1'b0;
        if (!rst) begin
            unique case (state_q)
                IDLE: begin
                    axi_awready = 1'b1;
                    axi_wready  = 1'b1;
                    axi_arready = !(axi_awvalid || axi_wvalid);
                end
                W_WAIT: begin
                    axi_awready = !aw_got_q;
                    axi_wready  = !w_got_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_got_q <= 1'b0;
            w_got_q  <= 1'b0;
            rvalid_q <= 1'b0;
            bvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
            bresp_q  <= RESP_OKAY;
        end else begin
            if (state_q == WRITE) begin
                aw_got_q <= 1'b0;
                w_got_q  <= 1'b0;
                bresp_q  <= aw_oor_q ? RESP_DECERR : RESP_OKAY;
            end else begin
                if (aw_hs) aw_got_q <= 1'b1;
                if (w_hs)  w_got_q  <= 1'b1;
            end
            if (state_q == B_RESP && !bvalid_q)  bvalid_q <= 1'b1;
            else if (bvalid_q && axi_bready)     bvalid_q <= 1'b0;
            // The RAM output register feeds the response register one cycle later.
            if (state_q == R_RESP && !rvalid_q) begin
                rvalid_q <= 1'b1;
                rdata_q  <= ar_oor_q ? 32'h0 : ram_rd_q;
                rresp_q  <= ar_oor_q ? RESP_DECERR : RESP_OKAY;
            end else if (rvalid_q && axi_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (aw_hs) begin
            aw_idx_q <= axi_awaddr[ADDR_WIDTH+1:2];
            aw_oor_q <= addr_oor(axi_awaddr);
        end
        if (w_hs) begin
            wdata_q <= axi_wdata;
            wstrb_q <= axi_wstrb;
        end
        if (ar_hs) begin
            ar_idx_q <= axi_araddr[ADDR_WIDTH+1:2];
            ar_oor_q <= addr_oor(axi_araddr);
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == WRITE && !aw_oor_q) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb_q[i]) mem_q[aw_idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
        if (state_q == READ) ram_rd_q <= mem_q[ar_idx_q];
    end

    assign axi_rdata  = rdata_q;
    assign axi_rresp  = rresp_q;
    assign axi_rvalid = rvalid_q;
    assign axi_bresp  = bresp_q;
    assign axi_bvalid = bvalid_q;

endmodule

// File: tb/tb_axi_lite_bram_slave.sv
// Scoreboard bench for axi_lite_bram_slave: directed transactions push expected responses,
// a negedge monitor pops and compares them on each R/B handshake.
module tb_axi_lite_bram_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] axi_araddr;
    logic        axi_arvalid;
    logic        axi_arready;
    logic [2:0]  axi_arprot;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rvalid;
    logic        axi_rready;
    logic [31:0] axi_awaddr;
    logic        axi_awvalid;
    logic        axi_awready;
    logic [2:0]  axi_awprot;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_wvalid;
    logic        axi_wready;
    logic [1:0]  axi_bresp;
    logic        axi_bvalid;
    logic        axi_bready;

    int n_checks = 0;
    int n_fail   = 0;
    logic [1:0]  exp_b [$];
    logic [33:0] exp_r [$];
    logic [1:0]  eb;
    logic [33:0] er;

    axi_lite_bram_slave #(.ADDR_WIDTH(12)) dut (
        .clk(clk), .rst(rst),
        .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_arprot(axi_arprot),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid),
        .axi_rready(axi_rready),
        .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_awprot(axi_awprot),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid),
        .axi_wready(axi_wready),
        .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Monitor: compare every completed response against the scoreboard.
    always @(negedge clk) begin
        if (axi_bvalid && axi_bready) begin
            check("b_expected", exp_b.size() != 0, 1);
            if (exp_b.size() != 0) begin
                eb = exp_b.pop_front();
                check("bresp", axi_bresp, eb);
            end
        end
        if (axi_rvalid && axi_rready) begin
            check("r_expected", exp_r.size() != 0, 1);
            if (exp_r.size() != 0) begin
                er = exp_r.pop_front();
                check("rdata", axi_rdata, er[31:0]);
                check("rresp", axi_rresp, er[33:32]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic aw_w(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        @(posedge clk); #1;
        axi_awaddr = addr; axi_awvalid = 1'b1;
        axi_wdata = data; axi_wstrb = strb; axi_wvalid = 1'b1;
        @(negedge clk);
        check("awready_idle", axi_awready, 1);
        check("wready_idle", axi_wready, 1);
        check("arready_blocked", axi_arready, 0);
        @(posedge clk); #1;
        axi_awvalid = 1'b0; axi_wvalid = 1'b0;
    endtask

    task automatic wait_b(input logic [1:0] exp, input int hold);
        exp_b.push_back(exp);
        @(negedge clk);
        check("arready_in_write", axi_arready, 0);
        @(negedge clk);
        check("bvalid_t1", axi_bvalid, 0);
        @(negedge clk);
        check("bvalid_t2", axi_bvalid, 1);
        repeat (hold) begin
            @(negedge clk);
            check("bvalid_hold", axi_bvalid, 1);
            check("bresp_hold", axi_bresp, exp);
            check("arready_bresp", axi_arready, 0);
        end
        @(posedge clk); #1 axi_bready = 1'b1;
        @(posedge clk); #1 axi_bready = 1'b0;
        @(negedge clk);
        check("bvalid_drop", axi_bvalid, 0);
    endtask

    task automatic rd_issue(input logic [31:0] addr);
        @(posedge clk); #1;
        axi_araddr = addr; axi_arvalid = 1'b1;
        @(negedge clk);
        check("arready_idle", axi_arready, 1);
        @(posedge clk); #1 axi_arvalid = 1'b0;
    endtask

    task automatic wait_r(input logic [31:0] data, input logic [1:0] resp, input int hold);
        exp_r.push_back({resp, data});
        @(negedge clk);
        @(negedge clk);
        check("rvalid_t1", axi_rvalid, 0);
        @(negedge clk);
        check("rvalid_t2", axi_rvalid, 1);
        repeat (hold) begin
            @(negedge clk);
            check("rvalid_hold", axi_rvalid, 1);
            check("rdata_hold", axi_rdata, data);
            check("rresp_hold", axi_rresp, resp);
        end
        @(posedge clk); #1 axi_rready = 1'b1;
        @(posedge clk); #1 axi_rready = 1'b0;
        @(negedge clk);
        check("rvalid_drop", axi_rvalid, 0);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp, input int hold);
        rd_issue(addr);
        wait_r(data, resp, hold);
    endtask

    initial begin
        rst = 1'b1;
        axi_araddr = '0; axi_arvalid = 1'b0; axi_arprot = 3'b0; axi_rready = 1'b0;
        axi_awaddr = '0; axi_awvalid = 1'b0; axi_awprot = 3'b0;
        axi_wdata = '0; axi_wstrb = '0; axi_wvalid = 1'b0; axi_bready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_awready", axi_awready, 0);
        check("rst_wready", axi_wready, 0);
        check("rst_arready", axi_arready, 0);
        check("rst_rvalid", axi_rvalid, 0);
        check("rst_bvalid", axi_bvalid, 0);
        check("rst_rdata", axi_rdata, 0);
        check("rst_rresp", axi_rresp, 0);
        check("rst_bresp", axi_bresp, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("idle_awready", axi_awready, 1);
        check("idle_arready", axi_arready, 1);

        // Full word, then byte-strobe merges (addr[1:0] ignored).
        aw_w(32'h10, 32'hDEADBEEF, 4'hF); wait_b(2'b00, 0);
        rd(32'h10, 32'hDEADBEEF, 2'b00, 0);
        aw_w(32'h10, 32'h00001122, 4'b0011); wait_b(2'b00, 5);
        rd(32'h10, 32'hDEAD1122, 2'b00, 0);
        aw_w(32'h10, 32'hFFFFFFFF, 4'b0000); wait_b(2'b00, 0);
        rd(32'h10, 32'hDEAD1122, 2'b00, 5);
        aw_w(32'h13, 32'h5A000000, 4'b1000); wait_b(2'b00, 0);
        rd(32'h11, 32'h5AAD1122, 2'b00, 0);

        // Split write: AW first, W three cycles later.
        @(posedge clk); #1;
        axi_awaddr = 32'h20; axi_awvalid = 1'b1;
        @(negedge clk);
        check("split_awready", axi_awready, 1);
        @(posedge clk); #1 axi_awvalid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("wwait_awready", axi_awready, 0);
            check("wwait_wready", axi_wready, 1);
            check("wwait_arready", axi_arready, 0);
            check("wwait_bvalid", axi_bvalid, 0);
        end
        @(posedge clk); #1;
        axi_wdata = 32'h12345678; axi_wstrb = 4'hF; axi_wvalid = 1'b1;
        @(negedge clk);
        check("split_wready", axi_wready, 1);
        @(posedge clk); #1 axi_wvalid = 1'b0;
        wait_b(2'b00, 0);
        rd(32'h20, 32'h12345678, 2'b00, 0);

        // Range boundaries: last word in range, first address out of range aliases word 0.
        aw_w(32'h0, 32'h01020304, 4'hF); wait_b(2'b00, 0);
        aw_w(32'h3FFC, 32'hA5A5A5A5, 4'hF); wait_b(2'b00, 0);
        aw_w(32'h4000, 32'hCAFEBABE, 4'hF); wait_b(2'b11, 3);
        rd(32'h0, 32'h01020304, 2'b00, 0);
        rd(32'h3FFC, 32'hA5A5A5A5, 2'b00, 0);
        rd(32'h4000, 32'h0, 2'b11, 2);

        // Priority: AR and AW/W together; write first, then the read sees the new data.
        @(posedge clk); #1;
        axi_awaddr = 32'h24; axi_wdata = 32'h0BADF00D; axi_wstrb = 4'hF;
        axi_awvalid = 1'b1; axi_wvalid = 1'b1;
        axi_araddr = 32'h24; axi_arvalid = 1'b1;
        @(negedge clk);
        check("prio_arready", axi_arready, 0);
        check("prio_awready", axi_awready, 1);
        @(posedge clk); #1 axi_awvalid = 1'b0; axi_wvalid = 1'b0;
        wait_b(2'b00, 2);
        check("prio_arready_idle", axi_arready, 1);
        @(posedge clk); #1 axi_arvalid = 1'b0;
        wait_r(32'h0BADF00D, 2'b00, 0);

        // Reset while in B_RESP: response discarded, committed write stays.
        aw_w(32'h30, 32'hAAAA5555, 4'hF);
        repeat (3) @(negedge clk);
        check("pre_rst_bvalid", axi_bvalid, 1);
        @(posedge clk); #1;
        rst = 1'b1; axi_awvalid = 1'b1; axi_wvalid = 1'b1; axi_arvalid = 1'b1;
        axi_awaddr = 32'h10; axi_wdata = 32'h77777777; axi_araddr = 32'h10;
        @(negedge clk);
        check("rst_force_awready", axi_awready, 0);
        check("rst_force_wready", axi_wready, 0);
        check("rst_force_arready", axi_arready, 0);
        @(negedge clk);
        check("rst_bvalid_drop", axi_bvalid, 0);
        @(posedge clk); #1;
        rst = 1'b0; axi_awvalid = 1'b0; axi_wvalid = 1'b0; axi_arvalid = 1'b0;
        rd(32'h30, 32'hAAAA5555, 2'b00, 0);

        // Reset while in W_WAIT: uncommitted write leaves RAM untouched.
        @(posedge clk); #1;
        axi_wdata = 32'hFFFFFFFF; axi_wstrb = 4'hF; axi_wvalid = 1'b1;
        @(negedge clk);
        check("wfirst_wready", axi_wready, 1);
        @(posedge clk); #1 axi_wvalid = 1'b0;
        @(negedge clk);
        check("wfirst_awready", axi_awready, 1);
        check("wfirst_wready_low", axi_wready, 0);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("rst2_awready", axi_awready, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rst2_bvalid", axi_bvalid, 0);
        check("rst2_wready", axi_wready, 1);
        rd(32'h10, 32'h5AAD1122, 2'b00, 0);

        repeat (3) @(posedge clk);
        check("b_queue_empty", exp_b.size(), 0);
        check("r_queue_empty", exp_r.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
